// File: rtl/put_arbiter.sv
// put_arbiter: round-robin arbiter feeding a 2-entry {src, payload} FIFO.
// Ports:
//   CLK, RST           clock, async active-low reset
//   req[N]             level request per requester
//   put[N*DW]          payload lanes, lane i at [i*DW +: DW]
//   EN_put[N]/RDY_put  per-requester enqueue handshake
//   get/get_src        FIFO head payload and originating port
//   EN_get/RDY_get     dequeue handshake
//   err                sticky protocol-violation flag
//   beats              16-bit wrapping count of accepted puts
module put_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_PORTS  = 2
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic [NUM_PORTS-1:0]            req,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] put,
    input  logic [NUM_PORTS-1:0]            EN_put,
    output logic [NUM_PORTS-1:0]            RDY_put,
    output logic [DATA_WIDTH-1:0]           get,
    output logic [1:0]                      get_src,
    input  logic                            EN_get,
    output logic                            RDY_get,
    output logic                            err,
    output logic [15:0]                     beats
);

    localparam int EW = DATA_WIDTH + 2;

    logic [NUM_PORTS-1:0] grant_q, grant_d;
    logic [1:0]           last_q, last_d;
    logic [EW-1:0]        mem0_q, mem0_d;
    logic [EW-1:0]        mem1_q, mem1_d;
    logic                 rd_ptr_q, rd_ptr_d;
    logic                 wr_ptr_q, wr_ptr_d;
    logic [1:0]           count_q, count_d;
    logic                 err_q, err_d;
    logic [15:0]          beats_q, beats_d;

    // Internal views padded to the 4-port maximum so that port
    // indices are always exactly two bits wide.
    logic [3:0]              gnt_w;
    logic [3:0]              req_w;
    logic [3:0]              pick_w;
    logic [4*DATA_WIDTH-1:0] put_w;

    logic                  full;
    logic [EW-1:0]         head;
    logic [1:0]            hold_idx;
    logic [DATA_WIDTH-1:0] hold_data;
    logic                  put_acc;
    logic                  get_acc;
    logic                  viol;
    logic                  holder_req;
    logic                  regrant;
    logic                  found;
    logic [2:0]            sum;

    // Handshake outputs depend only on registered state.
    always_comb begin
        full    = (count_q == 2'd2);
        RDY_put = full ? '0 : grant_q;
        RDY_get = (count_q != 2'd0);
        head    = rd_ptr_q ? mem1_q : mem0_q;
        get     = RDY_get ? head[DATA_WIDTH-1:0] : '0;
        get_src = RDY_get ? head[EW-1 -: 2] : 2'd0;
        err     = err_q;
        beats   = beats_q;
    end

    always_comb begin
        gnt_w = 4'(grant_q);
        req_w = 4'(req);
        put_w = (4*DATA_WIDTH)'(put);

        // One-hot grant to binary holder index.
        hold_idx = {gnt_w[3] | gnt_w[2], gnt_w[3] | gnt_w[1]};

        case (hold_idx)
            2'd0:    hold_data = put_w[0*DATA_WIDTH +: DATA_WIDTH];
            2'd1:    hold_data = put_w[1*DATA_WIDTH +: DATA_WIDTH];
            2'd2:    hold_data = put_w[2*DATA_WIDTH +: DATA_WIDTH];
            default: hold_data = put_w[3*DATA_WIDTH +: DATA_WIDTH];
        endcase

        put_acc    = |(EN_put & RDY_put);
        get_acc    = EN_get & RDY_get;
        viol       = (|(EN_put & ~RDY_put)) | (EN_get & ~RDY_get);
        holder_req = |(grant_q & req);
        regrant    = ~(|grant_q) | put_acc | ~holder_req;

        last_d = put_acc ? hold_idx : last_q;

        // Scan last+1 .. last (mod NUM_PORTS) from the updated
        // pointer, so a just-served port has lowest priority.
        pick_w = 4'd0;
        found  = 1'b0;
        sum    = 3'd0;
        for (int k = 1; k <= 4; k++) begin
            if (k <= NUM_PORTS) begin
                sum = {1'b0, last_d} + 3'(k);
                if (sum >= 3'(NUM_PORTS)) begin
                    sum = sum - 3'(NUM_PORTS);
                end
                if (!found && req_w[sum[1:0]]) begin
                    pick_w[sum[1:0]] = 1'b1;
                    found            = 1'b1;
                end
            end
        end

        grant_d = regrant ? NUM_PORTS'(pick_w) : grant_q;

        // Full blocks puts, so pop-then-push never overflows.
        mem0_d   = (put_acc && !wr_ptr_q) ? {hold_idx, hold_data} : mem0_q;
        mem1_d   = (put_acc &&  wr_ptr_q) ? {hold_idx, hold_data} : mem1_q;
        wr_ptr_d = wr_ptr_q ^ put_acc;
        rd_ptr_d = rd_ptr_q ^ get_acc;
        count_d  = count_q + 2'(put_acc) - 2'(get_acc);
        beats_d  = beats_q + 16'(put_acc);
        err_d    = err_q | viol;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            grant_q  <= '0;
            last_q   <= 2'(NUM_PORTS - 1);
            mem0_q   <= '0;
            mem1_q   <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            err_q    <= 1'b0;
            beats_q  <= 16'd0;
        end else begin
            grant_q  <= grant_d;
            last_q   <= last_d;
            mem0_q   <= mem0_d;
            mem1_q   <= mem1_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
            beats_q  <= beats_d;
        end
    end

endmodule
